// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : VGA raster timing with 2-cycle aligned sync/blank/pixel outputs.
//            Optional colour-bar generator enabled by macro TEST_PATTERN_EN.
// Revision : 1.0
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  iR,
    input  logic [7:0]  iG,
    input  logic [7:0]  iB,
`ifdef TEST_PATTERN_EN
    input  logic        iTP_SEL,
`endif
    output logic [15:0] oH_CNT,
    output logic [15:0] oV_CNT,
    output logic        oREQ,
    output logic [7:0]  oVGA_R,
    output logic [7:0]  oVGA_G,
    output logic [7:0]  oVGA_B,
    output logic        oHS,
    output logic        oVS,
    output logic        oBLANK_N,
    output logic        oFRAME_TICK
);

    localparam logic [15:0] c_H_ACTIVE = 16'(H_ACTIVE);
    localparam logic [15:0] c_H_LAST   = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [15:0] c_HS_START = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] c_HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] c_V_ACTIVE = 16'(V_ACTIVE);
    localparam logic [15:0] c_V_LAST   = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [15:0] c_VS_START = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] c_VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);

    logic [15:0] r_h_cnt_q, w_h_cnt_d;
    logic [15:0] r_v_cnt_q, w_v_cnt_d;
    logic        r_tick_q,  w_tick_d;
    logic        w_active;
    logic        r_hs1_q, w_hs1_d, r_hs2_q, w_hs2_d;
    logic        r_vs1_q, w_vs1_d, r_vs2_q, w_vs2_d;
    logic        r_blank1_q, w_blank1_d, r_blank2_q, w_blank2_d;
    logic [7:0]  r_red_q, w_red_d;
    logic [7:0]  r_grn_q, w_grn_d;
    logic [7:0]  r_blu_q, w_blu_d;
    logic [7:0]  w_src_r, w_src_g, w_src_b;

    always_comb begin
        w_h_cnt_d = r_h_cnt_q + 16'd1;
        w_v_cnt_d = r_v_cnt_q;
        if (r_h_cnt_q == c_H_LAST) begin
            w_h_cnt_d = 16'd0;
            w_v_cnt_d = (r_v_cnt_q == c_V_LAST) ? 16'd0 : r_v_cnt_q + 16'd1;
        end
        // Registered so the pulse coincides with the counters showing the last pixel
        w_tick_d = (w_h_cnt_d == c_H_LAST) && (w_v_cnt_d == c_V_LAST);
    end

    assign w_active = (r_h_cnt_q < c_H_ACTIVE) && (r_v_cnt_q < c_V_ACTIVE);

    always_comb begin
        w_hs1_d    = !((r_h_cnt_q >= c_HS_START) && (r_h_cnt_q < c_HS_END));
        w_vs1_d    = !((r_v_cnt_q >= c_VS_START) && (r_v_cnt_q < c_VS_END));
        w_blank1_d = w_active;
        w_hs2_d    = r_hs1_q;
        w_vs2_d    = r_vs1_q;
        w_blank2_d = r_blank1_q;
    end

`ifdef TEST_PATTERN_EN
    localparam logic [15:0] c_BAR_W = (H_ACTIVE >= 8) ? 16'(H_ACTIVE / 8) : 16'd1;

    logic [15:0] w_bar_full;
    logic [2:0]  r_bar_q, w_bar_d;

    always_comb begin
        w_bar_full = r_h_cnt_q / c_BAR_W;
        w_bar_d    = (w_bar_full > 16'd7) ? 3'd7 : w_bar_full[2:0];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_bar_q <= 3'd0;
        end else begin
            r_bar_q <= w_bar_d;
        end
    end

    // Bar order white..black maps each colour component to one inverted index bit
    always_comb begin
        w_src_r = iR;
        w_src_g = iG;
        w_src_b = iB;
        if (iTP_SEL) begin
            w_src_r = {8{~r_bar_q[1]}};
            w_src_g = {8{~r_bar_q[2]}};
            w_src_b = {8{~r_bar_q[0]}};
        end
    end
`else
    always_comb begin
        w_src_r = iR;
        w_src_g = iG;
        w_src_b = iB;
    end
`endif

    // Source data arrives one cycle after the request, alongside stage-1 blank
    always_comb begin
        w_red_d = r_blank1_q ? w_src_r : 8'h00;
        w_grn_d = r_blank1_q ? w_src_g : 8'h00;
        w_blu_d = r_blank1_q ? w_src_b : 8'h00;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_h_cnt_q  <= 16'd0;
            r_v_cnt_q  <= 16'd0;
            r_tick_q   <= 1'b0;
            r_hs1_q    <= 1'b1;
            r_vs1_q    <= 1'b1;
            r_blank1_q <= 1'b0;
            r_hs2_q    <= 1'b1;
            r_vs2_q    <= 1'b1;
            r_blank2_q <= 1'b0;
            r_red_q    <= 8'h00;
            r_grn_q    <= 8'h00;
            r_blu_q    <= 8'h00;
        end else begin
            r_h_cnt_q  <= w_h_cnt_d;
            r_v_cnt_q  <= w_v_cnt_d;
            r_tick_q   <= w_tick_d;
            r_hs1_q    <= w_hs1_d;
            r_vs1_q    <= w_vs1_d;
            r_blank1_q <= w_blank1_d;
            r_hs2_q    <= w_hs2_d;
            r_vs2_q    <= w_vs2_d;
            r_blank2_q <= w_blank2_d;
            r_red_q    <= w_red_d;
            r_grn_q    <= w_grn_d;
            r_blu_q    <= w_blu_d;
        end
    end

    assign oH_CNT      = r_h_cnt_q;
    assign oV_CNT      = r_v_cnt_q;
    assign oREQ        = w_active;
    assign oHS         = r_hs2_q;
    assign oVS         = r_vs2_q;
    assign oBLANK_N    = r_blank2_q;
    assign oFRAME_TICK = r_tick_q;
    assign oVGA_R      = r_red_q;
    assign oVGA_G      = r_grn_q;
    assign oVGA_B      = r_blu_q;

endmodule
`default_nettype wire
